// File: rtl/stream_packet_source.sv
// AXI-stream packet generator: on start, emits N packets of L beats with an
// optional idle gap; TDATA carries a run-relative timestamp starting at 0.
module stream_packet_source #(
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int LGPKTLEN          = 16,
  parameter int LGNPKTS           = 16,
  parameter int LGGAP             = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [LGPKTLEN-1:0]          i_pkt_len,
  input  logic [LGNPKTS-1:0]           i_num_pkts,
  input  logic [LGGAP-1:0]             i_gap,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                         M_AXIS_TLAST
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [LGPKTLEN-1:0]          LEN_ONE = LGPKTLEN'(1);
  localparam logic [LGNPKTS-1:0]           PKT_ONE = LGNPKTS'(1);
  localparam logic [LGGAP-1:0]             GAP_ONE = LGGAP'(1);
  localparam logic [C_AXIS_DATA_WIDTH-1:0] TS_ONE  = C_AXIS_DATA_WIDTH'(1);

  state_t                         state;
  logic [LGPKTLEN-1:0]            len_q;
  logic [LGNPKTS-1:0]             npkts_q;
  logic [LGGAP-1:0]               gap_q;
  logic [LGPKTLEN-1:0]            beat_cnt;
  logic [LGNPKTS-1:0]             pkt_cnt;
  logic [LGGAP-1:0]               gap_cnt;
  logic [C_AXIS_DATA_WIDTH-1:0]   ts;
  logic                           handshake;

  assign handshake = M_AXIS_TVALID && M_AXIS_TREADY;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the same pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      len_q         <= '0;
      npkts_q       <= '0;
      gap_q         <= '0;
      beat_cnt      <= '0;
      pkt_cnt       <= '0;
      gap_cnt       <= '0;
      ts            <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            if (i_pkt_len == '0 || i_num_pkts == '0) begin
              o_done <= 1'b1;
            end else begin
              state         <= S_SEND;
              len_q         <= i_pkt_len;
              npkts_q       <= i_num_pkts;
              gap_q         <= i_gap;
              beat_cnt      <= '0;
              pkt_cnt       <= '0;
              gap_cnt       <= '0;
              ts            <= '0;
              o_busy        <= 1'b1;
              M_AXIS_TVALID <= 1'b1;
              M_AXIS_TDATA  <= '0;
              M_AXIS_TLAST  <= (i_pkt_len == LEN_ONE);
            end
          end
        end

        S_SEND: begin
          ts <= ts + TS_ONE;
          if (handshake) begin
            if (M_AXIS_TLAST) begin
              beat_cnt <= '0;
              if (pkt_cnt == npkts_q - PKT_ONE) begin
                state         <= S_IDLE;
                o_busy        <= 1'b0;
                o_done        <= 1'b1;
                M_AXIS_TVALID <= 1'b0;
                M_AXIS_TLAST  <= 1'b0;
              end else begin
                pkt_cnt <= pkt_cnt + PKT_ONE;
                if (gap_q == '0) begin
                  // Next packet starts immediately; its first beat is stamped now.
                  M_AXIS_TDATA <= ts + TS_ONE;
                  M_AXIS_TLAST <= (len_q == LEN_ONE);
                end else begin
                  state         <= S_GAP;
                  gap_cnt       <= '0;
                  M_AXIS_TVALID <= 1'b0;
                  M_AXIS_TLAST  <= 1'b0;
                end
              end
            end else begin
              beat_cnt     <= beat_cnt + LEN_ONE;
              M_AXIS_TDATA <= ts + TS_ONE;
              M_AXIS_TLAST <= (beat_cnt + LEN_ONE == len_q - LEN_ONE);
            end
          end
        end

        S_GAP: begin
          ts      <= ts + TS_ONE;
          gap_cnt <= gap_cnt + GAP_ONE;
          if (gap_cnt == gap_q - GAP_ONE) begin
            state         <= S_SEND;
            beat_cnt      <= '0;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= ts + TS_ONE;
            M_AXIS_TLAST  <= (len_q == LEN_ONE);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
